// File: rtl/nts_api.sv
// nts_api: host-bus to internal register-file bridge.
// Decodes a 12-bit address onto six block selects; two-cycle access.
module nts_api (
  input  logic        i_clk,
  input  logic        i_areset,
  output logic        o_busy,
  input  logic        i_external_api_cs,
  input  logic        i_external_api_we,
  input  logic [11:0] i_external_api_address,
  input  logic [31:0] i_external_api_write_data,
  output logic [31:0] o_external_api_read_data,
  output logic        o_external_api_read_data_valid,
  output logic        o_internal_api_we,
  output logic [7:0]  o_internal_api_address,
  output logic [31:0] o_internal_api_write_data,
  output logic        o_internal_engine_api_cs,
  output logic        o_internal_clock_api_cs,
  output logic        o_internal_cookie_api_cs,
  output logic        o_internal_keymem_api_cs,
  output logic        o_internal_debug_api_cs,
  output logic        o_internal_parser_api_cs,
  input  logic [31:0] i_internal_engine_api_read_data,
  input  logic [31:0] i_internal_clock_api_read_data,
  input  logic [31:0] i_internal_cookie_api_read_data,
  input  logic [31:0] i_internal_keymem_api_read_data,
  input  logic [31:0] i_internal_debug_api_read_data,
  input  logic [31:0] i_internal_parser_api_read_data
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACCESS = 1'b1;

  localparam int ENG = 0;
  localparam int CLK = 1;
  localparam int COO = 2;
  localparam int KEY = 3;
  localparam int DBG = 4;
  localparam int PAR = 5;

  logic [0:0]  state_q, state_d;
  logic [5:0]  cs_q, cs_d;
  logic        we_q, we_d;
  logic [7:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        valid_q, valid_d;

  logic [5:0]  dec_cs;
  logic [7:0]  dec_addr;
  logic [31:0] sel_rdata;
  logic [11:0] a;

  assign a = i_external_api_address;

  always_comb begin
    dec_cs   = '0;
    dec_addr = '0;
    unique case (1'b1)
      (a[11:4] == 8'h00): begin
        dec_cs[ENG] = 1'b1;
        dec_addr    = a[7:0];
      end
      (a[11:4] == 8'h01): begin
        dec_cs[CLK] = 1'b1;
        dec_addr    = a[7:0] - 8'h10;
      end
      (a[11:7] == 5'h00 && a[6:5] != 2'b00): begin
        dec_cs[COO] = 1'b1;
        dec_addr    = a[7:0] - 8'h20;
      end
      (a[11:7] == 5'h01): begin
        dec_cs[KEY] = 1'b1;
        dec_addr    = a[7:0] - 8'h80;
      end
      (a[11:7] == 5'h03): begin
        dec_cs[DBG] = 1'b1;
        dec_addr    = a[7:0] - 8'h80;
      end
      (a[11:8] == 4'h2): begin
        dec_cs[PAR] = 1'b1;
        dec_addr    = a[7:0];
      end
      default: ;
    endcase
  end

  // Unmapped accesses leave cs_q empty, so reads fall through to zero.
  always_comb begin
    sel_rdata = '0;
    unique case (1'b1)
      cs_q[ENG]: sel_rdata = i_internal_engine_api_read_data;
      cs_q[CLK]: sel_rdata = i_internal_clock_api_read_data;
      cs_q[COO]: sel_rdata = i_internal_cookie_api_read_data;
      cs_q[KEY]: sel_rdata = i_internal_keymem_api_read_data;
      cs_q[DBG]: sel_rdata = i_internal_debug_api_read_data;
      cs_q[PAR]: sel_rdata = i_internal_parser_api_read_data;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cs_d    = cs_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_external_api_cs) begin
          state_d = ST_ACCESS;
          cs_d    = dec_cs;
          we_d    = i_external_api_we;
          addr_d  = dec_addr;
          wdata_d = i_external_api_write_data;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cs_d    = '0;
        we_d    = 1'b0;
        valid_d = 1'b1;
        rdata_d = we_q ? 32'h0 : sel_rdata;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_areset) begin
    if (!i_areset) begin
      state_q <= ST_IDLE;
      cs_q    <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cs_q    <= cs_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
    end
  end

  assign o_busy                         = (state_q == ST_ACCESS);
  assign o_external_api_read_data       = rdata_q;
  assign o_external_api_read_data_valid = valid_q;
  assign o_internal_api_we              = we_q;
  assign o_internal_api_address         = addr_q;
  assign o_internal_api_write_data      = wdata_q;
  assign o_internal_engine_api_cs       = cs_q[ENG];
  assign o_internal_clock_api_cs        = cs_q[CLK];
  assign o_internal_cookie_api_cs       = cs_q[COO];
  assign o_internal_keymem_api_cs       = cs_q[KEY];
  assign o_internal_debug_api_cs        = cs_q[DBG];
  assign o_internal_parser_api_cs       = cs_q[PAR];

endmodule

// File: tb/tb_nts_api.sv
// tb_nts_api: scoreboard bench for nts_api.
// Block models return {id, we, local addr}; parser is a 256-word memory.
module tb_nts_api;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        busy;
  logic        ext_cs;
  logic        ext_we;
  logic [11:0] ext_addr;
  logic [31:0] ext_wdata;
  logic [31:0] rdata;
  logic        valid;
  logic        int_we;
  logic [7:0]  int_addr;
  logic [31:0] int_wdata;
  logic        eng_cs, clk_cs, coo_cs, key_cs, dbg_cs, par_cs;
  logic [31:0] eng_rd, clk_rd, coo_rd, key_rd, dbg_rd, par_rd;
  logic [5:0]  cs_vec;

  logic [31:0] pmem [256];
  logic [31:0] sb [$];
  int          errors = 0;
  int          checks = 0;
  logic        eb = 1'b0;
  logic        ev = 1'b0;

  always #5 clk = ~clk;

  nts_api dut (
    .i_clk                            (clk),
    .i_areset                         (rst_n),
    .o_busy                           (busy),
    .i_external_api_cs                (ext_cs),
    .i_external_api_we                (ext_we),
    .i_external_api_address           (ext_addr),
    .i_external_api_write_data        (ext_wdata),
    .o_external_api_read_data         (rdata),
    .o_external_api_read_data_valid   (valid),
    .o_internal_api_we                (int_we),
    .o_internal_api_address           (int_addr),
    .o_internal_api_write_data        (int_wdata),
    .o_internal_engine_api_cs         (eng_cs),
    .o_internal_clock_api_cs          (clk_cs),
    .o_internal_cookie_api_cs         (coo_cs),
    .o_internal_keymem_api_cs         (key_cs),
    .o_internal_debug_api_cs          (dbg_cs),
    .o_internal_parser_api_cs         (par_cs),
    .i_internal_engine_api_read_data  (eng_rd),
    .i_internal_clock_api_read_data   (clk_rd),
    .i_internal_cookie_api_read_data  (coo_rd),
    .i_internal_keymem_api_read_data  (key_rd),
    .i_internal_debug_api_read_data   (dbg_rd),
    .i_internal_parser_api_read_data  (par_rd)
  );

  assign cs_vec = {par_cs, dbg_cs, key_cs, coo_cs, clk_cs, eng_cs};
  assign eng_rd = {8'h0A, 7'b0, int_we, 8'h00, int_addr};
  assign clk_rd = {8'h0B, 7'b0, int_we, 8'h00, int_addr};
  assign coo_rd = {8'h0C, 7'b0, int_we, 8'h00, int_addr};
  assign key_rd = {8'h0D, 7'b0, int_we, 8'h00, int_addr};
  assign dbg_rd = {8'h0E, 7'b0, int_we, 8'h00, int_addr};
  assign par_rd = pmem[int_addr];

  always @(posedge clk)
    if (par_cs && int_we) pmem[int_addr] <= int_wdata;

  // Reference timing: busy the cycle after a cs seen in idle, valid after that.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eb <= 1'b0;
      ev <= 1'b0;
    end else begin
      eb <= !eb && ext_cs;
      ev <= eb;
    end
  end

  always @(negedge clk) begin
    logic [31:0] exp;
    checks++;
    if (busy !== eb) begin
      errors++;
      $display("FAIL busy got %b exp %b t=%0t", busy, eb, $time);
    end
    checks++;
    if (valid !== ev) begin
      errors++;
      $display("FAIL valid got %b exp %b t=%0t", valid, ev, $time);
    end
    checks++;
    if ($isunknown(cs_vec) || $countones(cs_vec) > 1) begin
      errors++;
      $display("FAIL cs_onehot got %b exp <=1 hot t=%0t", cs_vec, $time);
    end
    if (!eb) begin
      checks++;
      if (cs_vec !== 6'b0) begin
        errors++;
        $display("FAIL cs_idle got %b exp 000000 t=%0t", cs_vec, $time);
      end
    end
    if (valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_empty got valid exp none t=%0t", $time);
      end else begin
        exp = sb.pop_front();
        if (rdata !== exp) begin
          errors++;
          $display("FAIL rdata got %h exp %h t=%0t", rdata, exp, $time);
        end
      end
    end
  end

  task automatic access(input logic we, input logic [11:0] a,
                        input logic [31:0] wd, input logic [31:0] exp_rd,
                        input logic [5:0] exp_cs, input logic [7:0] exp_la);
    bit got = 0;
    @(negedge clk);
    ext_cs = 1'b1;
    ext_we = we;
    ext_addr = a;
    ext_wdata = wd;
    sb.push_back(exp_rd);
    @(negedge clk);
    ext_cs = 1'b0;
    checks++;
    if (cs_vec !== exp_cs) begin
      errors++;
      $display("FAIL cs_sel a=%h got %b exp %b", a, cs_vec, exp_cs);
    end
    if (exp_cs != 6'b0) begin
      checks++;
      if (int_we !== we || int_addr !== exp_la || int_wdata !== wd) begin
        errors++;
        $display("FAIL int_bus a=%h got %b/%h/%h exp %b/%h/%h",
                 a, int_we, int_addr, int_wdata, we, exp_la, wd);
      end
    end
    for (int k = 0; k < 4 && !got; k++) begin
      @(negedge clk);
      if (valid === 1'b1) got = 1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL timeout a=%h got no valid exp valid", a);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    ext_cs = 1'b0;
    ext_we = 1'b0;
    ext_addr = '0;
    ext_wdata = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 0 || valid !== 0 || rdata !== 0 || int_we !== 0 ||
        int_addr !== 0 || int_wdata !== 0 || cs_vec !== 0) begin
      errors++;
      $display("FAIL reset got %b%b%h%b%h%h%b exp all zero",
               busy, valid, rdata, int_we, int_addr, int_wdata, cs_vec);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_read();
    access(1'b0, 12'h000, 32'h0, 32'h0A000000, 6'b000001, 8'h00);
    @(negedge clk);
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL valid_drop got %b exp 0", valid);
    end
    checks++;
    if (rdata !== 32'h0A000000) begin
      errors++;
      $display("FAIL rdata_hold got %h exp 0a000000", rdata);
    end
    access(1'b0, 12'h180, 32'h0, 32'h0E000000, 6'b010000, 8'h00);
    access(1'b0, 12'h010, 32'h0, 32'h0B000000, 6'b000010, 8'h00);
    access(1'b0, 12'h005, 32'h0, 32'h0A000005, 6'b000001, 8'h05);
    access(1'b0, 12'h07F, 32'h0, 32'h0C00005F, 6'b000100, 8'h5F);
    access(1'b0, 12'h0FF, 32'h0, 32'h0D00007F, 6'b001000, 8'h7F);
    access(1'b0, 12'h01F, 32'h0, 32'h0B00000F, 6'b000010, 8'h0F);
  endtask

  task automatic test_write();
    access(1'b1, 12'h023, 32'h9, 32'h0, 6'b000100, 8'h03);
    access(1'b1, 12'h082, 32'hE, 32'h0, 6'b001000, 8'h02);
  endtask

  task automatic test_unmapped();
    access(1'b0, 12'h100, 32'h0, 32'h0, 6'b000000, 8'h00);
    access(1'b0, 12'h17F, 32'h0, 32'h0, 6'b000000, 8'h00);
    access(1'b0, 12'h300, 32'h0, 32'h0, 6'b000000, 8'h00);
    access(1'b1, 12'hFFF, 32'h5, 32'h0, 6'b000000, 8'h00);
  endtask

  task automatic test_parser_mem();
    for (int i = 0; i < 256; i++)
      access(1'b1, 12'h200 + 12'(i), 32'd2147483647 + 32'(17 * i),
             32'h0, 6'b100000, 8'(i));
    for (int i = 0; i < 256; i++)
      access(1'b0, 12'h200 + 12'(i), 32'h0,
             32'd2147483647 + 32'(17 * i), 6'b100000, 8'(i));
  endtask

  task automatic test_back_to_back();
    logic [11:0] ba [4] = '{12'h001, 12'h015, 12'h1A3, 12'h004};
    logic [7:0]  bl [4] = '{8'h01, 8'h05, 8'h23, 8'h04};
    logic [31:0] be [4] = '{32'h0A000001, 32'h0B000005,
                            32'h0E000023, 32'h0A000004};
    @(negedge clk);
    ext_cs = 1'b1;
    ext_we = 1'b0;
    ext_addr = ba[0];
    sb.push_back(be[0]);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || int_addr !== bl[i]) begin
        errors++;
        $display("FAIL b2b_acc%0d got %b/%h exp 1/%h",
                 i, busy, int_addr, bl[i]);
      end
      if (i < 3) begin
        ext_addr = ba[i + 1];
        sb.push_back(be[i + 1]);
      end else begin
        ext_cs = 1'b0;
      end
      @(negedge clk);
      checks++;
      if (valid !== 1'b1) begin
        errors++;
        $display("FAIL b2b_valid%0d got %b exp 1", i, valid);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    ext_cs = 1'b1;
    ext_we = 1'b0;
    ext_addr = 12'h002;
    sb.push_back(32'h0A000002);
    @(negedge clk);
    ext_cs = 1'b0;
    checks++;
    if (busy !== 1'b1 || eng_cs !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre got %b/%b exp 1/1", busy, eng_cs);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 0 || cs_vec !== 0 || valid !== 0) begin
      errors++;
      $display("FAIL abort got %b/%b/%b exp 0/0/0", busy, cs_vec, valid);
    end
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    access(1'b0, 12'h00A, 32'h0, 32'h0A00000A, 6'b000001, 8'h0A);
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_unmapped();
    test_back_to_back();
    test_parser_mem();
    test_reset_mid();
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got %0d exp 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
